// File: rtl/sd_dat_pkg.sv
// Shared types and helpers for the SD DAT-line deserializer.
package sd_dat_pkg;

  // Block-level control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Lane mode: single DAT0 lane or the full M_MAX-bit bus.
  typedef enum logic {
    LANE_1    = 1'b0,
    LANE_WIDE = 1'b1
  } lane_mode_e;

  // Number of beats needed to fill one output word in the given lane mode.
  function automatic int unsigned beats_per_word(lane_mode_e  mode,
                                                 int unsigned n_width,
                                                 int unsigned m_max);
    return (mode == LANE_WIDE) ? (n_width / m_max) : n_width;
  endfunction

endpackage

// File: rtl/sd_word_buffer.sv
// Single-entry output register with valid/ready, last tag and sticky
// overflow detection. A word pushed while the held word is still waiting
// for its handshake is dropped and flags overflow.
module sd_word_buffer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             push_last_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             last_o,
  output logic             overflow_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             overflow_q, overflow_d;

  // Next-state: load on push when the slot is free or being drained this
  // edge, drop and flag otherwise, release on a plain handshake.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    data_d     = data_q;
    valid_d    = valid_q;
    last_d     = last_q;
    overflow_d = overflow_q;

    if (clear_i) begin
      overflow_d = 1'b0;
    end

    if (push_i && (!valid_q || ready_i)) begin
      data_d  = push_data_i;
      last_d  = push_last_i;
      valid_d = 1'b1;
    end else if (push_i) begin
      overflow_d = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  // Output register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from pre-edge values.
      data_q     <= data_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      overflow_q <= overflow_d;
    end
  end

  assign data_o     = data_q;
  assign valid_o    = valid_q;
  assign last_o     = last_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/sd_dat_deserializer.sv
// SD DAT-line deserializer: shifts 1-bit or M_MAX-bit beats MSB-first into
// N_WIDTH-bit words, frames BLOCK_WORDS words per block and hands them to a
// single-entry valid/ready output buffer.
module sd_dat_deserializer
  import sd_dat_pkg::*;
#(
  parameter int unsigned N_WIDTH     = 32,
  parameter int unsigned M_MAX       = 4,
  parameter int unsigned BLOCK_WORDS = 128,
  parameter int unsigned CNT_W       = 8
) (
  input  logic               sd_clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               mode_wide,
  input  logic               sample_en,
  input  logic [M_MAX-1:0]   serial_in,
  output logic [N_WIDTH-1:0] parallel_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy,
  output logic [CNT_W-1:0]   word_count,
  output logic               overflow
);

  localparam int unsigned BEAT_W = (N_WIDTH > 1) ? $clog2(N_WIDTH) : 1;

  state_e             state_q, state_d;
  lane_mode_e         mode_q, mode_d;
  logic [N_WIDTH-1:0] shift_q, shift_d;
  logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]   word_count_q, word_count_d;

  logic [N_WIDTH-1:0] shifted;
  logic [BEAT_W-1:0]  beat_last;
  logic               word_done;
  logic               word_last;
  logic               start_accept;

  // Shift register contents after accepting the current beat, and the
  // index of the final beat of a word for the latched lane mode.
  always_comb begin
    shifted   = (mode_q == LANE_WIDE) ? ((shift_q << M_MAX) | N_WIDTH'(serial_in))
                                      : ((shift_q << 1) | N_WIDTH'(serial_in[0]));
    beat_last = BEAT_W'(beats_per_word(mode_q, N_WIDTH, M_MAX) - 1);
  end

  // Block FSM, beat counter and word framing.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    shift_d      = shift_q;
    beat_cnt_d   = beat_cnt_q;
    word_count_d = word_count_q;
    word_done    = 1'b0;
    word_last    = 1'b0;
    start_accept = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = RECV;
          mode_d       = lane_mode_e'(mode_wide);
          shift_d      = '0;
          beat_cnt_d   = '0;
          word_count_d = '0;
          start_accept = 1'b1;
        end
      end
      RECV: begin
        if (sample_en) begin
          if (beat_cnt_q == beat_last) begin
            // Completed word leaves through the buffer; the shifter restarts
            // empty so the next beat can land without a stall.
            word_done    = 1'b1;
            word_last    = (word_count_q == CNT_W'(BLOCK_WORDS - 1));
            shift_d      = '0;
            beat_cnt_d   = '0;
            word_count_d = word_count_q + 1'b1;
            if (word_last) begin
              state_d = DRAIN;
            end
          end else begin
            shift_d    = shifted;
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        // The buffer always holds a word here (either the final one or the
        // one that blocked it), so its handshake closes the block.
        if (out_valid && out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and datapath registers.
  always_ff @(posedge sd_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      mode_q       <= LANE_1;
      shift_q      <= '0;
      beat_cnt_q   <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      shift_q      <= shift_d;
      beat_cnt_q   <= beat_cnt_d;
      word_count_q <= word_count_d;
    end
  end

  sd_word_buffer #(
    .WIDTH(N_WIDTH)
  ) u_word_buffer (
    .clk         (sd_clock),
    .rst_n       (reset_n),
    .clear_i     (start_accept),
    .push_i      (word_done),
    .push_data_i (shifted),
    .push_last_i (word_last),
    .ready_i     (out_ready),
    .data_o      (parallel_out),
    .valid_o     (out_valid),
    .last_o      (out_last),
    .overflow_o  (overflow)
  );

  assign busy       = (state_q != IDLE);
  assign word_count = word_count_q;

endmodule

// File: doc/sd_dat_deserializer.md
Name: sd_dat_deserializer

Overview:
- Next-generation SD DAT-line deserializer: assembles 1-bit or 4-bit DAT beats, MSB-first, into N-bit words for one data block.
- Adds the following to the fixed 4-to-32 converter:
  - runtime lane-mode select;
  - block framing with a last-word flag;
  - valid/ready output handshake with one word of buffering;
  - sticky overflow detection.
- Sits between the DAT line sampler and the host-side FIFO/DMA.

Parameters:
- N_WIDTH, 32, output word width; must be a multiple of M_MAX.
- M_MAX, 4, width of serial_in; the widest lane mode.
- BLOCK_WORDS, 128, words per block (512 bytes at N_WIDTH=32).
- CNT_W, 8, width of word_count; must satisfy 2**CNT_W >= BLOCK_WORDS.

Ports:
- sd_clock, input, 1, block clock; all logic on its rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle pulse that arms reception of one block.
- mode_wide, input, 1, 1 = M_MAX-bit lanes, 0 = 1-bit lane (serial_in[0] only); sampled on start.
- sample_en, input, 1, serial_in holds a valid beat this cycle.
- serial_in, input, M_MAX, DAT beat; bit M_MAX-1 is most significant.
- parallel_out, output, N_WIDTH, assembled word.
- out_valid, output, 1, parallel_out valid.
- out_ready, input, 1, consumer accepts the word.
- out_last, output, 1, qualifies parallel_out as the final word of the block.
- busy, output, 1, state is not IDLE.
- word_count, output, CNT_W, words assembled so far in the current block.
- overflow, output, 1, sticky: a completed word was dropped.

Behaviour:
- Reset (async assert, sync release): state IDLE, shift register 0, beat counter 0.
  - Outputs on reset: parallel_out=0, out_valid=0, out_last=0, busy=0, word_count=0, overflow=0.
- States: IDLE, RECV, DRAIN.
  - IDLE->RECV on start. Latches mode_wide, clears word_count, clears overflow.
  - RECV->DRAIN on the edge that completes word BLOCK_WORDS.
  - DRAIN->IDLE on the handshake of the last word (out_valid && out_ready).
- Beats per word: N_WIDTH/M_MAX in wide mode, N_WIDTH in narrow mode.
- Shift direction: MSB-first. The first beat lands in the top bits: [N-1 -: M_MAX] wide, [N-1] narrow.
- sample_en is ignored in IDLE and DRAIN.
- start is ignored while busy.
- Word completion: on the edge that accepts the final beat, the word moves to the output register. out_valid rises that same edge, so the word is visible in the next cycle. Latency is 1 clock from the last beat.
  - word_count increments on that edge.
  - out_last is set together with out_valid when word_count reaches BLOCK_WORDS.
- The shift register is free for the next beat immediately; back-to-back beats cause no stall.
- Handshake:
  - parallel_out, out_valid and out_last hold stable while out_valid=1 and out_ready=0.
  - out_valid clears on the handshake edge unless a new word completes on the same edge. In that case the new word replaces the old one and out_valid stays 1.
- Overflow: a word completes while out_valid=1 and out_ready=0.
  - The new word is dropped and the held word is kept.
  - overflow is set and stays set until the next start or reset.
  - word_count still increments, so block framing stays aligned.
- Reset mid-block: all state is discarded immediately; no partial word is emitted.
- A partial word at start is impossible: start clears the beat counter and the shift register.

Decomposition:
- Package sd_dat_pkg holds:
  - state enum {IDLE, RECV, DRAIN};
  - lane mode constants LANE_1, LANE_WIDE;
  - function beats_per_word(mode, N_WIDTH, M_MAX).
- One sub-module, sd_word_buffer: the single-entry output register with valid/ready, the last tag and the overflow detect.
- The shift register, beat counter and FSM stay in the top level.

Test Plan:
- Wide mode: start with mode_wide=1, then 8 beats 0x1..0x8 continuous -> parallel_out=0x12345678, out_valid 1 cycle after beat 8, word_count=1.
- Narrow mode: start with mode_wide=0, then 32 beats of serial_in[0] spelling 0xA5A5_0F0F (serial_in[3:1]=0x7 noise) -> parallel_out=0xA5A50F0F.
- Full block: BLOCK_WORDS=4, wide mode, out_ready held 1, gapped sample_en -> 4 words, out_last only on word 4, busy falls after the 4th handshake.
- Backpressure: out_ready=0 during word 2 and word 3 completion -> word 1 held, overflow=1, word_count=3; the next start clears overflow.
- Same-edge handshake and completion: out_ready pulsed on the edge word 2 completes -> out_valid stays 1, parallel_out = word 2, overflow stays 0.
- Async reset asserted after 5 beats -> all outputs 0 immediately. After release, a fresh start with 8 beats yields a correct word with no residue.
